key_sched_ctrl: RTL and testbench
=================================

KEY_SCHED_CTRL -- requirements
Module: key_sched_ctrl

Interface
REQ-001 SHALL have parameter NROUNDS, default 10, number of round keys issued per run (legal 2..15).
REQ-002 SHALL have parameter RC_W, default 4, round-index output width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port start  input  1  request a key-schedule run; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  cancel the run in progress.
REQ-007 SHALL have port rk_ready  input  1  consumer accepts the current round key.
REQ-008 SHALL have port reg_en  output  1  enable to the 64-bit key register.
REQ-009 SHALL have port reg_ld  output  1  load key register from its x input (drives the register's rst/load pin).
REQ-010 SHALL have port reg_sh16  output  1  rotate-by-16 command.
REQ-011 SHALL have port reg_sh5  output  1  rotate-by-5 command.
REQ-012 SHALL have port reg_sr  output  1  sub-round modifier, asserted together with reg_sh5.
REQ-013 SHALL have port rk_valid  output  1  key register output is the current round key.
REQ-014 SHALL have port round_idx  output  RC_W  index of the current round key, 0..NROUNDS-1.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse after the last round key is accepted.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, KEY, ROT16, ROT5, DONE; all outputs decoded from registered state (Moore), no input-to-output combinational path.
REQ-018 IDLE: start=1 -> LOAD; otherwise stay; round counter held at 0.
REQ-019 LOAD: reg_en=1, reg_ld=1 for exactly one cycle -> KEY.
REQ-020 KEY: rk_valid=1, round_idx=counter; stay while rk_ready=0 with reg_en=0, so the register holds.
REQ-021 KEY with rk_ready=1: counter==NROUNDS-1 -> DONE, else -> ROT16.
REQ-022 ROT16: reg_en=1, reg_sh16=1 for one cycle -> ROT5.
REQ-023 ROT5: reg_en=1, reg_sh5=1, reg_sr=1 for one cycle; counter increments -> KEY.
REQ-024 DONE: done=1, busy=1 for one cycle -> IDLE.
REQ-025 reg_ld, reg_sh16, reg_sh5 SHALL be mutually exclusive; each SHALL be 1 only when reg_en=1.
REQ-026 With rk_ready tied 1, key k SHALL appear in the cycle 2+3k after start is sampled; done at cycle 3*NROUNDS.
REQ-027 start while busy SHALL be ignored (no restart, no queuing).
REQ-028 abort=1 in any non-IDLE state SHALL move to IDLE next cycle, clear the counter, and suppress done; abort in IDLE is ignored.
REQ-029 abort and rk_ready both high in KEY: abort wins; the key counts as not accepted.
REQ-030 Round counter SHALL never wrap: it saturates at NROUNDS-1 (KEY exits to DONE there).

Reset
REQ-031 rst=1 SHALL immediately force state IDLE and counter 0, independent of clk.
REQ-032 During and after reset all outputs SHALL be 0 (reg_en, reg_ld, reg_sh16, reg_sh5, reg_sr, rk_valid, busy, done, round_idx).
REQ-033 Reset mid-run SHALL drop the run without a done pulse; first start after release behaves as REQ-018.

Structure
REQ-034 State encoding constants, default NROUNDS and RC_W SHALL live in a shared package key_sched_pkg, reused by the cipher top level.
REQ-035 The block SHALL be a single module with no sub-modules; the key register is instantiated beside it, not inside it.

Verification
REQ-036 Reset release, start=1 one cycle, rk_ready=1 -> reg_ld at cycle 1; rk_valid with round_idx 0..9 at cycles 2,5,..,29; done at cycle 30 only; busy cycles 1..30.
REQ-037 Controller plus key register, x=64'h1234_5678_9abc_def0 -> round-0 key equals x; round-1 key equals x after rot16 then rot5/sr as computed by the bench's reference model.
REQ-038 rk_ready low 4 cycles at round 3 -> rk_valid held 5 cycles, round_idx=3 stable, reg_en=0 throughout; schedule resumes, done is delayed by 4 cycles.
REQ-039 abort asserted in ROT16 of round 5 -> IDLE next cycle, no done, busy=0; new start gives round_idx 0 again.
REQ-040 start pulsed at round 2 and rst asserted mid-cycle in round 6 -> start ignored; outputs 0 asynchronously, no done pulse.
REQ-041 Every cycle assertion: at most one of reg_ld/reg_sh16/reg_sh5 high, none without reg_en, reg_sr only with reg_sh5.

Source files
------------

// File: rtl/key_sched_pkg.sv
// Shared definitions for the key-schedule controller and the cipher top level:
// FSM state encoding, default round count/index width, and register command decode.
package key_sched_pkg;

    localparam int KS_NROUNDS_DEF = 10;
    localparam int KS_RC_W_DEF    = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_KEY   = 3'd2,
        ST_ROT16 = 3'd3,
        ST_ROT5  = 3'd4,
        ST_DONE  = 3'd5
    } ks_state_e;

    // Command bundle for the external 64-bit key register.
    typedef struct packed {
        logic en;
        logic ld;
        logic sh16;
        logic sh5;
        logic sr;
    } ks_reg_cmd_t;

    // Each command bit is tied to exactly one state, so ld/sh16/sh5 are
    // exclusive by construction and never appear without en.
    function automatic ks_reg_cmd_t ks_cmd_for(input ks_state_e st);
        ks_reg_cmd_t cmd;
        cmd = '0;
        case (st)
            ST_LOAD:  begin cmd.en = 1'b1; cmd.ld   = 1'b1; end
            ST_ROT16: begin cmd.en = 1'b1; cmd.sh16 = 1'b1; end
            ST_ROT5:  begin cmd.en = 1'b1; cmd.sh5  = 1'b1; cmd.sr = 1'b1; end
            default:  cmd = '0;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/key_sched_ctrl.sv
// Key-schedule sequencer: loads the key register, then alternates round-key
// hand-off with rot16 / rot5+sr steps for NROUNDS rounds. Moore outputs only.
module key_sched_ctrl
    import key_sched_pkg::*;
#(
    parameter int NROUNDS = KS_NROUNDS_DEF,
    parameter int RC_W    = KS_RC_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic            rk_ready,
    output logic            reg_en,
    output logic            reg_ld,
    output logic            reg_sh16,
    output logic            reg_sh5,
    output logic            reg_sr,
    output logic            rk_valid,
    output logic [RC_W-1:0] round_idx,
    output logic            busy,
    output logic            done
);

    localparam logic [RC_W-1:0] LAST_ROUND = RC_W'(NROUNDS - 1);

    ks_state_e       state_q, state_d;
    logic [RC_W-1:0] cnt_q, cnt_d;
    ks_reg_cmd_t     cmd;

    // NOTE: sequential state uses non-blocking assignments only; all next-state
    // logic lives in always_comb so the flops see a single, race-free update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: defaults are assigned first so no path through the case leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (start) state_d = ST_LOAD;
                ST_LOAD:  state_d = ST_KEY;
                ST_KEY: begin
                    if (rk_ready) begin
                        state_d = (cnt_q == LAST_ROUND) ? ST_DONE : ST_ROT16;
                    end
                end
                ST_ROT16: state_d = ST_ROT5;
                ST_ROT5:  state_d = ST_KEY;
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Counter advances only on leaving ROT5 and saturates at the last round;
    // abort and run completion both return it to zero for the next start.
    always_comb begin
        cnt_d = cnt_q;
        if (abort && state_q != ST_IDLE) begin
            cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: cnt_d = '0;
                ST_ROT5: begin
                    if (cnt_q != LAST_ROUND) cnt_d = cnt_q + RC_W'(1);
                end
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_comb begin
        cmd       = ks_cmd_for(state_q);
        reg_en    = cmd.en;
        reg_ld    = cmd.ld;
        reg_sh16  = cmd.sh16;
        reg_sh5   = cmd.sh5;
        reg_sr    = cmd.sr;
        rk_valid  = (state_q == ST_KEY);
        round_idx = cnt_q;
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ($countones({reg_ld, reg_sh16, reg_sh5}) <= 1);
            assert (reg_en || !(reg_ld || reg_sh16 || reg_sh5));
            assert (reg_sh5 || !reg_sr);
        end
    end

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Scoreboard bench for key_sched_ctrl with a behavioural 64-bit key register
// beside it; expected round keys come from a rotate/xor reference function.
module tb_key_sched_ctrl;
    import key_sched_pkg::*;

    localparam int NR = 10;
    localparam int RC = 4;
    localparam logic [63:0] SR_MASK = 64'h0000_0000_0000_005A;

    logic          clk = 1'b0;
    logic          rst, start, abort, rk_ready;
    logic          reg_en, reg_ld, reg_sh16, reg_sh5, reg_sr, rk_valid, busy, done;
    logic [RC-1:0] round_idx;
    logic [63:0]   x, kreg;

    typedef struct {
        logic [RC-1:0] idx;
        logic [63:0]   key;
    } exp_t;

    exp_t exp_q[$];
    int   exp_done = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    key_sched_ctrl #(.NROUNDS(NR), .RC_W(RC)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .rk_ready(rk_ready),
        .reg_en(reg_en), .reg_ld(reg_ld), .reg_sh16(reg_sh16), .reg_sh5(reg_sh5),
        .reg_sr(reg_sr), .rk_valid(rk_valid), .round_idx(round_idx),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Key register that the controller drives.
    always @(posedge clk or posedge rst) begin
        if (rst) kreg <= '0;
        else if (reg_en) begin
            if (reg_ld)        kreg <= x;
            else if (reg_sh16) kreg <= {kreg[47:0], kreg[63:48]};
            else if (reg_sh5)  kreg <= {kreg[58:0], kreg[63:59]} ^ (reg_sr ? SR_MASK : 64'h0);
        end
    end

    function automatic logic [63:0] rotl(input logic [63:0] v, input int n);
        return (v << n) | (v >> (64 - n));
    endfunction

    // Round k key: k applications of (rotate 16, then rotate 5 and xor modifier).
    function automatic logic [63:0] ref_key(input logic [63:0] k0, input int k);
        logic [63:0] v;
        v = k0;
        for (int i = 0; i < k; i++) v = rotl(rotl(v, 16), 5) ^ SR_MASK;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic flush;
        exp_q.delete();
        exp_done = 0;
    endtask

    // Issues start for one cycle and queues the whole run's expected keys.
    task automatic launch(input logic [63:0] key);
        exp_t e;
        x = key;
        for (int k = 0; k < NR; k++) begin
            e.idx = RC'(k);
            e.key = ref_key(key, k);
            exp_q.push_back(e);
        end
        exp_done++;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to_done(input int budget);
        int n;
        n = 0;
        rk_ready = 1'b1;
        while ((exp_q.size() != 0 || exp_done != 0) && n < budget) begin
            @(negedge clk);
            tick();
            n++;
        end
        check("run_completes_in_budget", 64'(n < budget), 64'd1);
    endtask

    // Monitor: per-cycle command rules, reset outputs, key and done scoreboard.
    always @(negedge clk) begin
        exp_t e;
        check("cmd_exclusive", 64'($countones({reg_ld, reg_sh16, reg_sh5}) <= 1), 64'd1);
        check("cmd_needs_en", 64'(reg_en || !(reg_ld || reg_sh16 || reg_sh5)), 64'd1);
        check("sr_only_with_sh5", 64'(reg_sh5 || !reg_sr), 64'd1);
        if (rst) begin
            check("outputs_in_reset",
                  64'({reg_en, reg_ld, reg_sh16, reg_sh5, reg_sr, rk_valid, busy, done, round_idx}), 64'd0);
        end else begin
            if (rk_valid && rk_ready && !abort) begin
                check("key_was_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("round_idx", 64'(round_idx), 64'(e.idx));
                    check("round_key", kreg, e.key);
                end
            end
            if (done) begin
                check("done_was_expected", 64'(exp_done > 0), 64'd1);
                check("done_after_last_key", 64'(exp_q.size()), 64'd0);
                if (exp_done > 0) exp_done--;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic exp_valid;
        int   exp_idx;
        logic abort_now;

        rst = 1'b1; start = 1'b0; abort = 1'b0; rk_ready = 1'b1;
        x = 64'h1234_5678_9abc_def0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset_state",
              64'({reg_en, reg_ld, reg_sh16, reg_sh5, reg_sr, rk_valid, busy, done, round_idx}), 64'd0);
        tick();

        // Nominal run with rk_ready tied high: exact cycle schedule.
        launch(64'h1234_5678_9abc_def0);
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            exp_valid = (c >= 2 && c <= 29 && (c - 2) % 3 == 0);
            check("t1_rk_valid", 64'(rk_valid), 64'(exp_valid));
            if (exp_valid) check("t1_round_idx", 64'(round_idx), 64'((c - 2) / 3));
            if (c == 2) check("t1_key0_is_x", kreg, 64'h1234_5678_9abc_def0);
            if (c == 5) check("t1_key1", kreg, ref_key(64'h1234_5678_9abc_def0, 1));
            check("t1_reg_ld", 64'(reg_ld), 64'(c == 1));
            check("t1_done", 64'(done), 64'(c == 30));
            check("t1_busy", 64'(busy), 64'(c <= 30));
            tick();
        end

        // Consumer stalls four cycles on round 3.
        launch(64'h0f1e_2d3c_4b5a_6978);
        for (int c = 1; c <= 36; c++) begin
            rk_ready = !(c >= 11 && c <= 14);
            @(negedge clk);
            exp_valid = (c >= 2 && c <= 8 && (c - 2) % 3 == 0) || (c >= 11 && c <= 15) ||
                        (c >= 18 && c <= 33 && (c - 18) % 3 == 0);
            exp_idx   = (c <= 8) ? (c - 2) / 3 : (c <= 15) ? 3 : (c - 6) / 3;
            check("t2_rk_valid", 64'(rk_valid), 64'(exp_valid));
            if (exp_valid) check("t2_round_idx", 64'(round_idx), 64'(exp_idx));
            if (c >= 11 && c <= 15) check("t2_reg_en_held", 64'(reg_en), 64'd0);
            check("t2_done", 64'(done), 64'(c == 34));
            check("t2_busy", 64'(busy), 64'(c <= 34));
            tick();
        end
        rk_ready = 1'b1;

        // Abort in ROT16 of round 5.
        launch(64'hdead_beef_0bad_f00d);
        for (int c = 1; c <= 25; c++) begin
            abort = (c == 18);
            if (c == 19) flush();
            @(negedge clk);
            if (c == 18) check("t3_in_rot16", 64'(reg_sh16), 64'd1);
            if (c >= 19) begin
                check("t3_idle_busy", 64'(busy), 64'd0);
                check("t3_idle_valid", 64'(rk_valid), 64'd0);
                check("t3_cnt_cleared", 64'(round_idx), 64'd0);
            end
            check("t3_no_done", 64'(done), 64'd0);
            tick();
        end
        abort = 1'b0;
        launch(64'h5555_aaaa_3333_cccc);
        @(negedge clk);
        tick();
        @(negedge clk);
        check("t3_restart_idx0", 64'(round_idx), 64'd0);
        check("t3_restart_valid", 64'(rk_valid), 64'd1);
        tick();
        run_to_done(100);

        // Start while busy is ignored; reset mid-cycle in round 6 drops the run.
        launch(64'h0123_4567_89ab_cdef);
        for (int c = 1; c <= 20; c++) begin
            start = (c == 8);
            @(negedge clk);
            if (c == 9) check("t4_no_reload", 64'(reg_ld), 64'd0);
            if (c == 11) check("t4_round3_idx", 64'(round_idx), 64'd3);
            if (c == 20) begin
                check("t4_round6_valid", 64'(rk_valid), 64'd1);
                #2 rst = 1'b1;
                #1;
                check("t4_async_reset",
                      64'({reg_en, reg_ld, reg_sh16, reg_sh5, reg_sr, rk_valid, busy, done, round_idx}),
                      64'd0);
                flush();
            end
            tick();
        end
        start = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t4_idle_after_reset", 64'({busy, done}), 64'd0);
            tick();
        end
        launch(64'hfedc_ba98_7654_3210);
        run_to_done(100);

        // Abort in IDLE is ignored: start in the same cycle still loads.
        abort = 1'b1;
        launch(64'h1111_2222_3333_4444);
        abort = 1'b0;
        @(negedge clk);
        check("t5_abort_idle_ignored", 64'(reg_ld), 64'd1);
        tick();
        run_to_done(100);

        // Randomised runs: stalls, start noise while busy, occasional abort.
        for (int r = 0; r < 12; r++) begin
            int n;
            n = 0;
            launch({$urandom, $urandom});
            while ((exp_q.size() != 0 || exp_done != 0) && n < 400) begin
                rk_ready  = ($urandom_range(0, 3) != 0);
                start     = (exp_q.size() != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                abort_now = (exp_q.size() != 0) && ($urandom_range(0, 79) == 0);
                abort     = abort_now;
                @(negedge clk);
                tick();
                if (abort_now) begin
                    abort = 1'b0;
                    start = 1'b0;
                    flush();
                end
                n++;
            end
            check("rand_run_in_budget", 64'(n < 400), 64'd1);
            start = 1'b0; abort = 1'b0; rk_ready = 1'b1;
            tick();
            @(negedge clk);
            check("rand_back_to_idle", 64'(busy), 64'd0);
            tick();
        end

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
